request_unit: RTL and testbench

//  Memory-request sequencer downstream of the control unit in the single-cycle MIPS datapath.
//  - Consumes the control unit's dRead/dWrite/halt decode and the caches' ihit/dhit.
//  - Drives the instruction and data request enables toward the caches.
//  - Produces the PC enable, and holds a sticky halt.
//  - Keeps saturating performance counters for instructions retired and stall cycles.

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/sat_counter.sv | 19 +
 rtl/request_unit.sv | 123 ++++++++++++
 tb/tb_request_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types; holds the request sequencer state encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MEM   = 2'd1,
        HALT  = 2'd2
    } reqstate_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: fetch / data-access / halt control with
// saturating retire and stall counters and a sticky protocol-error flag.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             cu_dRead,
    input  logic             cu_dWrite,
    input  logic             cu_halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic             req_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    reqstate_t       state, next_state;
    logic            rd_q, wr_q, err_q;
    logic            next_rd, next_wr, next_err;
    logic [WD_W-1:0] wd_q, next_wd;

    // State register plus latched access kind, watchdog and error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            state <= next_state;
            rd_q  <= next_rd;
            wr_q  <= next_wr;
            err_q <= next_err;
            wd_q  <= next_wd;
        end
    end

    // Next-state and request/retire decode
    always_comb begin
        next_state = state;
        next_rd    = rd_q;
        next_wr    = wr_q;
        next_err   = err_q;
        next_wd    = wd_q;
        imemREN    = 1'b0;
        pc_en      = 1'b0;

        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (cu_halt) begin
                        next_state = HALT;
                    end else if (cu_dRead || cu_dWrite) begin
                        next_state = MEM;
                        next_rd    = cu_dRead & ~cu_dWrite;
                        next_wr    = cu_dWrite;
                        next_wd    = '0;
                        if (cu_dRead && cu_dWrite) begin
                            next_err = 1'b1;
                        end
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            MEM: begin
                if (dhit) begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                    next_rd    = 1'b0;
                    next_wr    = 1'b0;
                end else if (MEM_TIMEOUT != 0) begin
                    // Flag a stuck access but keep waiting for it
                    if (wd_q == WD_W'(MEM_TIMEOUT - 1)) begin
                        next_err = 1'b1;
                    end
                    if (wd_q != WD_W'(MEM_TIMEOUT)) begin
                        next_wd = wd_q + WD_W'(1);
                    end
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign dmemREN = rd_q;
    assign dmemWEN = wr_q;
    assign halt    = (state == HALT);
    assign req_err = err_q;

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (pc_en),
        .cnt  (instr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (~pc_en & ~halt),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: instruction-level reference model feeds
// an expectation queue that a negedge monitor drains and compares.
module tb_request_unit;

    localparam int unsigned CW  = 3;
    localparam int unsigned TO  = 4;
    localparam int          SAT = 7;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ihit = 1'b0, dhit = 1'b0;
    logic          cu_dRead = 1'b0, cu_dWrite = 1'b0, cu_halt = 1'b0;
    logic          imemREN, dmemREN, dmemWEN, pc_en, halt, req_err;
    logic [CW-1:0] instr_cnt, stall_cnt;

    request_unit #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .dhit      (dhit),
        .cu_dRead  (cu_dRead),
        .cu_dWrite (cu_dWrite),
        .cu_halt   (cu_halt),
        .imemREN   (imemREN),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .pc_en     (pc_en),
        .halt      (halt),
        .req_err   (req_err),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit rst;
        bit imem, dren, dwen, pc, hlt, err;
        int ic, sc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: one outstanding instruction at a time
    bit m_halted, m_busy, m_store, m_err;
    int m_age, m_ic, m_sc;

    function void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function void model_reset();
        m_halted = 0; m_busy = 0; m_store = 0; m_err = 0;
        m_age = 0; m_ic = 0; m_sc = 0;
    endfunction

    task automatic step(input bit r, input bit ih, input bit dh,
                        input bit rd, input bit wr, input bit hl);
        exp_t e;
        bit   retire;
        @(posedge CLK);
        #1;
        nRST = r; ihit = ih; dhit = dh; cu_dRead = rd; cu_dWrite = wr; cu_halt = hl;
        e = '{default: 0};
        if (!r) begin
            model_reset();
            e.rst = 1;
        end else begin
            if (m_halted)    retire = 0;
            else if (m_busy) retire = dh;
            else             retire = ih && !hl && !rd && !wr;
            e.hlt  = m_halted;
            e.err  = m_err;
            e.ic   = m_ic;
            e.sc   = m_sc;
            e.imem = !m_halted && !m_busy;
            e.dren = m_busy && !m_store;
            e.dwen = m_busy && m_store;
            e.pc   = retire;
            if (retire) m_ic = (m_ic + 1 > SAT) ? SAT : m_ic + 1;
            if (!retire && !m_halted) m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
            if (!m_halted) begin
                if (m_busy) begin
                    if (dh) m_busy = 0;
                    else begin
                        m_age++;
                        if (m_age == TO) m_err = 1;
                    end
                end else if (ih) begin
                    if (hl) m_halted = 1;
                    else if (rd || wr) begin
                        m_busy  = 1;
                        m_store = wr;
                        m_age   = 0;
                        if (rd && wr) m_err = 1;
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("dmemREN", int'(dmemREN), int'(mon_e.dren));
            chk("dmemWEN", int'(dmemWEN), int'(mon_e.dwen));
            chk("halt", int'(halt), int'(mon_e.hlt));
            chk("req_err", int'(req_err), int'(mon_e.err));
            chk("instr_cnt", int'(instr_cnt), mon_e.ic);
            chk("stall_cnt", int'(stall_cnt), mon_e.sc);
            if (!mon_e.rst) begin
                chk("imemREN", int'(imemREN), int'(mon_e.imem));
                chk("pc_en", int'(pc_en), int'(mon_e.pc));
            end
        end
    end

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);

        // Three plain fetch hits
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("t1_instr_cnt", int'(instr_cnt), 3);
        chk("t1_stall_cnt", int'(stall_cnt), 0);

        // Load with dhit on second MEM cycle
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("t2_instr_cnt", int'(instr_cnt), 1);
        chk("t2_stall_cnt", int'(stall_cnt), 2);

        // Load+store together: store wins, error sticks
        step(1, 1, 0, 1, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Halt absorbs everything until reset
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0);
        #2;
        chk("t4_halt", int'(halt), 1);
        repeat (4) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(0, 0, 0, 0, 0, 0);

        // Store with dhit withheld six MEM cycles trips the watchdog
        step(1, 1, 0, 0, 1, 0);
        repeat (6) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Reset mid-MEM, then saturate the retire counter
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        repeat (9) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        #2;
        chk("t6_instr_sat", int'(instr_cnt), 7);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 29) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 24) == 0));
        end

        step(1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
